// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle for the register file: read ports, write port, reservation port.
// The design uses the slave modport. The driver of reads, writes and reservations uses master.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [XLEN/8-1:0]     wr_be;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  rsv_ok;
    logic [NREGS-1:0]      busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ok, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ok, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with byte-enabled writes and optional write-to-read bypass.
// It also keeps a per-register busy scoreboard for destinations that are still in flight.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic clk,
    input  logic rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int AW     = $clog2(NREGS);
    localparam int NBYTES = XLEN / 8;

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_nxt;
    logic                  wr_act;
    logic                  wr_hit;
    logic                  rsv_zero;
    logic                  rsv_ok;
    logic [XLEN-1:0]       wr_merged;
    logic [AW-1:0]         ra;
    logic                  byp;
    logic [NREAD*XLEN-1:0] rd_data_c;
    logic [NREAD-1:0]      rd_busy_c;

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old_word,
                                                    input logic [XLEN-1:0]   new_word,
                                                    input logic [NBYTES-1:0] be);
        logic [XLEN-1:0] res;
        res = old_word;
        for (int k = 0; k < NBYTES; k++) begin
            if (be[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
        end
        return res;
    endfunction

    // A write presented while reset is held must not be visible, not even through the bypass.
    assign wr_act    = bus.wr_en & rst_n;
    assign wr_hit    = wr_act && !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign wr_merged = merge_bytes(regs[bus.wr_addr], bus.wr_data, bus.wr_be);

    assign rsv_zero  = (ZERO_REG != 0) && (bus.rsv_addr == '0);
    assign rsv_ok    = bus.rsv_en & ~busy[bus.rsv_addr] & ~rsv_zero;

    // The clear from the write is applied first, so an accepted reservation of the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_act) busy_nxt[bus.wr_addr] = 1'b0;
        if (rsv_ok) busy_nxt[bus.rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            busy <= busy_nxt;
            if (wr_hit) regs[bus.wr_addr] <= wr_merged;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        byp       = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = bus.rd_addr[i*AW +: AW];
            byp = (BYPASS != 0) && wr_hit && (ra == bus.wr_addr);
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data_c[i*XLEN +: XLEN] = '0;
                rd_busy_c[i]              = 1'b0;
            end else if (byp) begin
                rd_data_c[i*XLEN +: XLEN] = wr_merged;
                rd_busy_c[i]              = 1'b0;
            end else begin
                rd_data_c[i*XLEN +: XLEN] = regs[ra];
                rd_busy_c[i]              = busy[ra];
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.rsv_ok   = rsv_ok;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives identical stimulus into a bypassing and a non-bypassing register file.
// Both are compared against an array-based model of registers and busy flags.
module tb_regfile_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_b ();
    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_n ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(0))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    logic        c_we;
    logic [4:0]  c_wa;
    logic [31:0] c_wd;
    logic [3:0]  c_be;
    logic        c_re;
    logic [4:0]  c_ra;
    logic [4:0]  c_r0;
    logic [4:0]  c_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = 32'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic same_cycle_write(input int byp, input logic [4:0] a);
        return (byp != 0) && rst_n && c_we && (c_wa == a) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input int byp, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (same_cycle_write(byp, a)) return merge(m_mem[a], c_wd, c_be);
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int byp, input logic [4:0] a);
        if (same_cycle_write(byp, a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ok();
        return c_re && (c_ra != 5'd0) && !m_busy[c_ra];
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic apply();
        bus_b.wr_en = c_we;  bus_b.wr_addr = c_wa;  bus_b.wr_data = c_wd;  bus_b.wr_be = c_be;
        bus_b.rsv_en = c_re; bus_b.rsv_addr = c_ra; bus_b.rd_addr = {c_r1, c_r0};
        bus_n.wr_en = c_we;  bus_n.wr_addr = c_wa;  bus_n.wr_data = c_wd;  bus_n.wr_be = c_be;
        bus_n.rsv_en = c_re; bus_n.rsv_addr = c_ra; bus_n.rd_addr = {c_r1, c_r0};
    endtask

    task automatic check_now(input string tag);
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("%s_b%0d_rd0", tag, b),
                b != 0 ? bus_b.rd_data[31:0] : bus_n.rd_data[31:0], exp_data(b, c_r0));
            chk($sformatf("%s_b%0d_rd1", tag, b),
                b != 0 ? bus_b.rd_data[63:32] : bus_n.rd_data[63:32], exp_data(b, c_r1));
            chk($sformatf("%s_b%0d_busy0", tag, b),
                b != 0 ? 32'(bus_b.rd_busy[0]) : 32'(bus_n.rd_busy[0]), 32'(exp_busy(b, c_r0)));
            chk($sformatf("%s_b%0d_busy1", tag, b),
                b != 0 ? 32'(bus_b.rd_busy[1]) : 32'(bus_n.rd_busy[1]), 32'(exp_busy(b, c_r1)));
            chk($sformatf("%s_b%0d_ok", tag, b),
                b != 0 ? 32'(bus_b.rsv_ok) : 32'(bus_n.rsv_ok), 32'(exp_ok()));
            chk($sformatf("%s_b%0d_vec", tag, b),
                b != 0 ? bus_b.busy_vec : bus_n.busy_vec, exp_vec());
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [4:0] ra,
                         input logic [4:0] r0, input logic [4:0] r1, input string tag);
        c_we = we; c_wa = wa; c_wd = wd; c_be = be; c_re = re; c_ra = ra; c_r0 = r0; c_r1 = r1;
        apply();
        #3;
        check_now(tag);
    endtask

    task automatic drive_idle(input logic [4:0] r0, input logic [4:0] r1, input string tag);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, r0, r1, tag);
    endtask

    // Reservation is applied after the write's clear, so it wins on a free register.
    task automatic tick();
        logic ok;
        @(posedge clk);
        if (rst_n) begin
            ok = exp_ok();
            if (c_we && c_wa != 5'd0) m_mem[c_wa] = merge(m_mem[c_wa], c_wd, c_be);
            if (c_we) m_busy[c_wa] = 1'b0;
            if (ok) m_busy[c_ra] = 1'b1;
        end
        #1;
    endtask

    initial begin
        c_we = 0; c_wa = 0; c_wd = 0; c_be = 0; c_re = 0; c_ra = 0; c_r0 = 0; c_r1 = 0;
        apply();
        model_reset();
        #1;
        check_now("reset");
        chk("reset_vec", bus_b.busy_vec, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1, 5'd5, 32'hDEADBEEF, 4'hF, 0, 5'd0, 5'd5, 5'd5, "w5");
        tick();
        drive_idle(5'd5, 5'd5, "r5");
        chk("r5_before_rst", bus_n.rd_data[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("r5_in_rst", bus_n.rd_data[31:0], 32'h0);
        chk("vec_in_rst", bus_b.busy_vec, 32'h0);
        tick();
        drive(1, 5'd6, 32'h01234567, 4'hF, 1, 5'd6, 5'd6, 5'd6, "in_rst");
        chk("rst_rsv_ok", 32'(bus_b.rsv_ok), 32'h1);
        chk("rst_no_bypass", bus_b.rd_data[63:32], 32'h0);
        tick();
        rst_n = 1'b1;
        drive_idle(5'd6, 5'd5, "post_rst");
        chk("post_rst_vec", bus_b.busy_vec, 32'h0);
        tick();

        drive(1, 5'd3, 32'h12345678, 4'hF, 0, 5'd0, 5'd3, 5'd0, "w3a");
        tick();
        drive(1, 5'd3, 32'hAABBCCDD, 4'h5, 0, 5'd0, 5'd3, 5'd0, "w3b");
        tick();
        drive_idle(5'd3, 5'd3, "r3");
        chk("r3_merge_n", bus_n.rd_data[31:0], 32'h12BB56DD);
        chk("r3_merge_b", bus_b.rd_data[63:32], 32'h12BB56DD);
        tick();

        drive(1, 5'd7, 32'hCAFEF00D, 4'hF, 0, 5'd0, 5'd3, 5'd7, "w7");
        chk("byp_on_same_cycle", bus_b.rd_data[63:32], 32'hCAFEF00D);
        chk("byp_off_old", bus_n.rd_data[63:32], 32'h0);
        tick();
        drive_idle(5'd0, 5'd7, "r7");
        chk("byp_off_new", bus_n.rd_data[63:32], 32'hCAFEF00D);
        tick();

        drive(1, 5'd0, 32'hFFFFFFFF, 4'hF, 1, 5'd0, 5'd0, 5'd0, "zero");
        chk("zero_rsv_ok", 32'(bus_b.rsv_ok), 32'h0);
        chk("zero_rd", bus_b.rd_data[31:0], 32'h0);
        tick();
        drive_idle(5'd0, 5'd0, "zero_after");
        chk("zero_vec0", 32'(bus_b.busy_vec[0]), 32'h0);
        chk("zero_rd_after", bus_n.rd_data[31:0], 32'h0);
        tick();

        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd9, 5'd9, 5'd0, "rsv9");
        chk("r9_ok", 32'(bus_b.rsv_ok), 32'h1);
        tick();
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd9, 5'd9, 5'd0, "rsv9_again");
        chk("r9_vec", 32'(bus_b.busy_vec[9]), 32'h1);
        chk("r9_again_ok", 32'(bus_b.rsv_ok), 32'h0);
        tick();
        drive(1, 5'd9, 32'h99990000, 4'hF, 0, 5'd0, 5'd9, 5'd9, "w9");
        chk("r9_byp_busy", 32'(bus_b.rd_busy[0]), 32'h0);
        chk("r9_nobyp_busy", 32'(bus_n.rd_busy[0]), 32'h1);
        tick();
        drive_idle(5'd9, 5'd0, "r9_after");
        chk("r9_cleared", 32'(bus_b.busy_vec[9]), 32'h0);
        tick();

        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd4, 5'd4, 5'd0, "rsv4");
        tick();
        drive(1, 5'd4, 32'h11112222, 4'hF, 1, 5'd4, 5'd4, 5'd0, "col_busy");
        chk("col_busy_ok", 32'(bus_n.rsv_ok), 32'h0);
        tick();
        drive_idle(5'd4, 5'd0, "col_busy_after");
        chk("col_busy_vec", 32'(bus_n.busy_vec[4]), 32'h0);
        chk("col_busy_data", bus_n.rd_data[31:0], 32'h11112222);
        tick();
        drive(1, 5'd4, 32'h33334444, 4'hF, 1, 5'd4, 5'd0, 5'd4, "col_free");
        chk("col_free_ok", 32'(bus_b.rsv_ok), 32'h1);
        tick();
        drive_idle(5'd4, 5'd0, "col_free_after");
        chk("col_free_vec", 32'(bus_b.busy_vec[4]), 32'h1);
        chk("col_free_data", bus_n.rd_data[31:0], 32'h33334444);
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a_w, a_r, a_0, a_1;
            a_w = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a_r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a_0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a_1 = ($urandom_range(0, 1) == 0) ? a_w : 5'($urandom_range(0, 7));
            if (n == 200) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (n == 202) rst_n = 1'b1;
            drive(1'($urandom), a_w, $urandom, 4'($urandom), 1'($urandom), a_r, a_0, a_1, "rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the processor's integer register file.
- Adds configurable width, depth and read-port count, byte-enabled writes, and asynchronous clear.
- Adds optional write-to-read bypass and a per-register busy scoreboard that tracks in-flight destination registers.
- Sits between decode (reads, reservations) and writeback (writes) in the single-cycle core and its planned pipelined variant.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- NREGS, 32, number of architectural registers; must be a power of 2, minimum 2.
- NREAD, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NREAD  busy flag of each read port's register.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write destination register.
- wr_data  in  XLEN  write data.
- wr_be  in  XLEN/8  byte enables for the write.
- rsv_en  in  1  reservation request; marks rsv_addr as pending.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- busy_vec  out  NREGS  full scoreboard, bit r = register r busy.

Behaviour:
- Reset:
  - rst_n low clears all registers to 0 and all busy bits to 0 immediately, independent of clk.
  - During and after reset: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - rsv_ok = rsv_en (and rsv_addr != 0 when ZERO_REG=1).
  - Writes and reservations presented while rst_n is low are discarded.
- Write:
  - On a rising edge with wr_en=1, byte k of wr_addr is replaced by wr_data byte k wherever wr_be[k]=1; other bytes are unchanged.
  - wr_be = 0 updates no data but still clears the busy bit.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 with rd_busy = 0.
  - rsv_en with rsv_addr = 0 gives rsv_ok = 0 and no state change.
- Read:
  - Combinational; zero latency from rd_addr to rd_data.
  - With BYPASS=1, wr_en=1 and rd_addr[i] == wr_addr (non-zero when ZERO_REG=1), rd_data[i] = stored value merged with wr_data under wr_be, in the same cycle.
  - With BYPASS=0, reads return the stored value; the new value is visible from the cycle after the edge.
  - Multiple ports may read the same address.
- Scoreboard:
  - rsv_ok = rsv_en & ~busy[rsv_addr]; combinational on current state.
  - Accepted reservation sets busy[rsv_addr] at the next edge.
  - Rejected reservation (already busy) changes nothing; the requester must retry.
  - A write with wr_en=1 clears busy[wr_addr] at the edge.
  - rd_busy[i] = busy[rd_addr[i]], except that with BYPASS=1 a same-cycle write to that address forces it to 0.
- Simultaneous events on the same edge:
  - Write to A and reservation of B != A: both take effect.
  - Write to A and reservation of A, A not busy: reservation wins; A is busy afterwards and the data is written.
  - Write to A and reservation of A, A busy: write clears the bit; rsv_ok=0; A is not busy afterwards.
- Out-of-range addresses cannot occur, because NREGS is a power of 2.
- Writing a non-busy register is legal; busy stays 0.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle -> rd_data for r5 = 0 immediately, busy_vec = 0.
- Write r3 = 0x12345678 with wr_be=4'b1111, then r3 = 0xAABBCCDD with wr_be=4'b0101 -> r3 reads 0x12BB56DD.
- Bypass (BYPASS=1): in the same cycle, write r7 = 0xCAFEF00D while port 1 reads r7 -> rd_data port 1 = 0xCAFEF00D before the edge. With BYPASS=0 -> old value before the edge, new value after.
- Zero register: write r0 = 0xFFFFFFFF with rsv_en, rsv_addr=0 -> r0 reads 0, rsv_ok=0, busy_vec[0]=0.
- Scoreboard:
  - Reserve r9 -> rsv_ok=1; next cycle busy_vec[9]=1.
  - Reserve r9 again -> rsv_ok=0.
  - Write r9 -> busy_vec[9]=0 after the edge.
- Collision: with r4 busy, write r4 and reserve r4 in the same cycle -> rsv_ok=0, busy_vec[4]=0; repeat with r4 free -> rsv_ok=1, busy_vec[4]=1, data written.
